ra_wr_arb: RTL and testbench

- Arbitrates the single write port of the 64x72 2R1W register array between two independent write requesters.
- Each requester has a valid/ready handshake into its own small FIFO.
- A registered arbiter drains the FIFOs onto wr_enb_0/wr_adr_0/wr_dat_0, using round-robin or fixed priority.
- Sits between the requesters and the BIST mux write inputs; wr_hold lets BIST or config freeze issue without losing queued writes.

---
 rtl/ra_pkg.sv | 24 ++
 rtl/ra_wr_arb_if.sv | 47 ++++
 rtl/ra_wr_fifo.sv | 63 ++++++
 rtl/ra_wr_arb.sv | 115 +++++++++++
 tb/tb_ra_wr_arb.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ra_pkg.sv
`default_nettype none
//==============================================================================
// Module      : ra_pkg
// Description : Shared widths, arbitration mode encodings and the write-request
//               record used around the 64x72 2R1W register array.
// Revision    : 1.0 - initial release
//==============================================================================
package ra_pkg;

    localparam int RA_AW = 6;
    localparam int RA_DW = 72;

    // Arbitration mode encodings for the write-port arbiter
    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    // One array write: address plus data
    typedef struct packed {
        logic [RA_AW-1:0] adr;
        logic [RA_DW-1:0] dat;
    } ra_wr_req_t;

endpackage : ra_pkg
`default_nettype wire

// File: rtl/ra_wr_arb_if.sv
`default_nettype none
//==============================================================================
// Module      : ra_wr_arb_if
// Description : Requester handshakes, arbitration controls and the array write
//               port of the write arbiter, bundled as one interface.
// Revision    : 1.0 - initial release
//==============================================================================
interface ra_wr_arb_if #(
    parameter int AW = ra_pkg::RA_AW,
    parameter int DW = ra_pkg::RA_DW
);

    logic          req0_val;
    logic          req0_rdy;
    logic [AW-1:0] req0_adr;
    logic [DW-1:0] req0_dat;
    logic          req1_val;
    logic          req1_rdy;
    logic [AW-1:0] req1_adr;
    logic [DW-1:0] req1_dat;
    logic          mode;
    logic          wr_hold;
    logic          wr_enb_0;
    logic [AW-1:0] wr_adr_0;
    logic [DW-1:0] wr_dat_0;
    logic          busy;

    // Requester / control side
    modport master (
        output req0_val, req0_adr, req0_dat,
        output req1_val, req1_adr, req1_dat,
        output mode, wr_hold,
        input  req0_rdy, req1_rdy,
        input  wr_enb_0, wr_adr_0, wr_dat_0, busy
    );

    // Arbiter side
    modport slave (
        input  req0_val, req0_adr, req0_dat,
        input  req1_val, req1_adr, req1_dat,
        input  mode, wr_hold,
        output req0_rdy, req1_rdy,
        output wr_enb_0, wr_adr_0, wr_dat_0, busy
    );

endinterface : ra_wr_arb_if
`default_nettype wire

// File: rtl/ra_wr_fifo.sv
`default_nettype none
//==============================================================================
// Module      : ra_wr_fifo
// Description : Small per-requester write FIFO. Full/empty come from a count
//               one bit wider than the naturally wrapping pointers.
// Revision    : 1.0 - initial release
//==============================================================================
module ra_wr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 78
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;

    // Storage: written on push only; contents need no reset since count gates use
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rptr];
    assign empty = (r_count == '0);
    assign full  = (r_count == c_FULL_CNT);

endmodule : ra_wr_fifo
`default_nettype wire

// File: rtl/ra_wr_arb.sv
`default_nettype none
//==============================================================================
// Module      : ra_wr_arb
// Description : Two-requester arbiter for the register array's single write
//               port. Each requester queues into its own FIFO; a registered
//               round-robin / fixed-priority arbiter drains them, one write per
//               cycle, and wr_hold freezes issue without dropping queued writes.
// Revision    : 1.0 - initial release
//==============================================================================
module ra_wr_arb
    import ra_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = RA_AW,
    parameter int DW    = RA_DW
) (
    input wire logic   clk,
    input wire logic   reset,
    ra_wr_arb_if.slave bus
);

    localparam int c_W = AW + DW;

    logic           w_full0, w_full1;
    logic           w_empty0, w_empty1;
    logic [c_W-1:0] w_head0, w_head1;
    logic           w_rdy0, w_rdy1;
    logic           w_push0, w_push1;
    logic           w_pop0, w_pop1;
    logic           w_gnt_vld;
    logic           w_gnt_sel;
    logic [c_W-1:0] w_gnt_head;

    logic           r_last;
    logic           r_wr_enb;
    logic [AW-1:0]  r_wr_adr;
    logic [DW-1:0]  r_wr_dat;

    // Ready comes from registered occupancy only, and is held low during reset
    assign w_rdy0  = reset & ~w_full0;
    assign w_rdy1  = reset & ~w_full1;
    assign w_push0 = bus.req0_val & w_rdy0;
    assign w_push1 = bus.req1_val & w_rdy1;
    assign w_pop0  = w_gnt_vld & ~w_gnt_sel;
    assign w_pop1  = w_gnt_vld &  w_gnt_sel;

    ra_wr_fifo #(.DEPTH(DEPTH), .WIDTH(c_W)) u_fifo0 (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push0),
        .push_data ({bus.req0_adr, bus.req0_dat}),
        .pop       (w_pop0),
        .head      (w_head0),
        .empty     (w_empty0),
        .full      (w_full0)
    );

    ra_wr_fifo #(.DEPTH(DEPTH), .WIDTH(c_W)) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push1),
        .push_data ({bus.req1_adr, bus.req1_dat}),
        .pop       (w_pop1),
        .head      (w_head1),
        .empty     (w_empty1),
        .full      (w_full1)
    );

    // Grant decision from the FIFO heads; on contention RR picks the requester
    // that did not win last, fixed priority always picks requester 0
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_sel = 1'b0;
        if (!bus.wr_hold) begin
            if (!w_empty0 && !w_empty1) begin
                w_gnt_vld = 1'b1;
                w_gnt_sel = (bus.mode == ARB_FIXED) ? 1'b0 : ~r_last;
            end else if (!w_empty0) begin
                w_gnt_vld = 1'b1;
                w_gnt_sel = 1'b0;
            end else if (!w_empty1) begin
                w_gnt_vld = 1'b1;
                w_gnt_sel = 1'b1;
            end
        end
        w_gnt_head = w_gnt_sel ? w_head1 : w_head0;
    end

    // Last-grant pointer (starts at 1 so requester 0 wins the first tie) and
    // the registered write port; address/data hold when nothing is granted
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last   <= 1'b1;
            r_wr_enb <= 1'b0;
            r_wr_adr <= '0;
            r_wr_dat <= '0;
        end else begin
            r_wr_enb <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_last   <= w_gnt_sel;
                r_wr_adr <= w_gnt_head[c_W-1:DW];
                r_wr_dat <= w_gnt_head[DW-1:0];
            end
        end
    end

    assign bus.req0_rdy = w_rdy0;
    assign bus.req1_rdy = w_rdy1;
    assign bus.wr_enb_0 = r_wr_enb;
    assign bus.wr_adr_0 = r_wr_adr;
    assign bus.wr_dat_0 = r_wr_dat;
    assign bus.busy     = ~w_empty0 | ~w_empty1 | r_wr_enb;

endmodule : ra_wr_arb
`default_nettype wire

// File: tb/tb_ra_wr_arb.sv
`default_nettype none
//==============================================================================
// Module      : tb_ra_wr_arb
// Description : Self-checking bench for ra_wr_arb: queue-based reference model
//               compared every cycle, directed scenarios with literal
//               expectations, then randomized traffic.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ra_wr_arb;
    import ra_pkg::*;

    localparam int DEPTH = 2;
    localparam int AW    = RA_AW;
    localparam int DW    = RA_DW;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ra_wr_arb_if #(.AW(AW), .DW(DW)) bus ();

    ra_wr_arb #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    ra_wr_req_t    q0[$];
    ra_wr_req_t    q1[$];
    logic          m_last;
    logic          m_enb;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat;
    bit            m_p0, m_p1;
    int            m_sel;
    ra_wr_req_t    m_r;

    // Log of writes seen on the array port
    logic [AW-1:0] wl_adr[$];
    logic [DW-1:0] wl_dat[$];
    int            wl_cyc[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: queues updated at each edge from the inputs present in that cycle
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                q0.delete();
                q1.delete();
                m_last = 1'b1;
                m_enb  = 1'b0;
                m_adr  = '0;
                m_dat  = '0;
            end else begin
                m_p0  = bus.req0_val && (q0.size() < DEPTH);
                m_p1  = bus.req1_val && (q1.size() < DEPTH);
                m_sel = -1;
                if (!bus.wr_hold) begin
                    if (q0.size() > 0 && q1.size() > 0)
                        m_sel = (bus.mode == ARB_FIXED) ? 0 : (m_last ? 0 : 1);
                    else if (q0.size() > 0)
                        m_sel = 0;
                    else if (q1.size() > 0)
                        m_sel = 1;
                end
                if (m_sel >= 0) begin
                    m_r    = (m_sel == 0) ? q0.pop_front() : q1.pop_front();
                    m_enb  = 1'b1;
                    m_adr  = m_r.adr;
                    m_dat  = m_r.dat;
                    m_last = (m_sel == 1);
                end else begin
                    m_enb = 1'b0;
                end
                if (m_p0) q0.push_back('{adr: bus.req0_adr, dat: bus.req0_dat});
                if (m_p1) q1.push_back('{adr: bus.req1_adr, dat: bus.req1_dat});
            end
        end
    end

    // Compare every cycle on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            check("wr_enb_0", bus.wr_enb_0, m_enb);
            check("wr_adr_0", bus.wr_adr_0, m_adr);
            check("wr_dat_0", bus.wr_dat_0, m_dat);
            check("req0_rdy", bus.req0_rdy, reset && (q0.size() < DEPTH));
            check("req1_rdy", bus.req1_rdy, reset && (q1.size() < DEPTH));
            check("busy", bus.busy, (q0.size() > 0) || (q1.size() > 0) || m_enb);
            if (bus.wr_enb_0 === 1'b1) begin
                wl_adr.push_back(bus.wr_adr_0);
                wl_dat.push_back(bus.wr_dat_0);
                wl_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        wl_adr.delete();
        wl_dat.delete();
        wl_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        clear_log();
    endtask

    function automatic logic [DW-1:0] rnd_dat();
        return DW'({$urandom(), $urandom(), $urandom()});
    endfunction

    // Two pushes on each requester (under whatever hold is currently applied)
    task automatic preload(input logic [AW-1:0] a0, input logic [AW-1:0] b0,
                           input logic [AW-1:0] a1, input logic [AW-1:0] b1);
        bus.req0_val = 1'b1; bus.req0_adr = a0; bus.req0_dat = rnd_dat();
        bus.req1_val = 1'b1; bus.req1_adr = a1; bus.req1_dat = rnd_dat();
        tick();
        bus.req0_adr = b0; bus.req0_dat = rnd_dat();
        bus.req1_adr = b1; bus.req1_dat = rnd_dat();
        tick();
        bus.req0_val = 1'b0;
        bus.req1_val = 1'b0;
    endtask

    // Compare the logged write addresses against a literal sequence
    task automatic check_seq(input string name, input int n,
                             input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                             input logic [AW-1:0] e2, input logic [AW-1:0] e3);
        logic [AW-1:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({name, "_count"}, wl_adr.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < wl_adr.size())
                check($sformatf("%s_adr%0d", name, i), wl_adr[i], e[i]);
        end
    endtask

    int hs;
    bit r0_s, r1_s;

    initial begin
        bus.req0_val = 1'b0; bus.req0_adr = '0; bus.req0_dat = '0;
        bus.req1_val = 1'b0; bus.req1_adr = '0; bus.req1_dat = '0;
        bus.mode     = ARB_RR;
        bus.wr_hold  = 1'b0;
        reset        = 1'b0;

        // Reset held for three cycles
        repeat (3) tick();
        check("rst_enb",  bus.wr_enb_0, 0);
        check("rst_adr",  bus.wr_adr_0, 0);
        check("rst_dat",  bus.wr_dat_0, 0);
        check("rst_rdy0", bus.req0_rdy, 0);
        check("rst_rdy1", bus.req1_rdy, 0);
        check("rst_busy", bus.busy, 0);
        reset = 1'b1;
        tick();
        check("rel_rdy0", bus.req0_rdy, 1);
        check("rel_rdy1", bus.req1_rdy, 1);

        // Single write: two-cycle latency, then idle
        clear_log();
        bus.req0_val = 1'b1; bus.req0_adr = 6'd5; bus.req0_dat = {9{8'hA5}};
        hs = cyc;
        tick();
        bus.req0_val = 1'b0;
        repeat (4) tick();
        check("single_count", wl_adr.size(), 1);
        if (wl_adr.size() >= 1) begin
            check("single_latency", wl_cyc[0] - hs, 2);
            check("single_adr", wl_adr[0], 6'd5);
            check("single_dat", wl_dat[0], {9{8'hA5}});
        end
        check("single_busy_idle", bus.busy, 0);

        // Round-robin: strict alternation on consecutive cycles
        do_reset();
        bus.wr_hold = 1'b1;
        bus.mode    = ARB_RR;
        preload(6'h10, 6'h11, 6'h20, 6'h21);
        clear_log();
        bus.wr_hold = 1'b0;
        repeat (6) tick();
        check_seq("rr", 4, 6'h10, 6'h20, 6'h11, 6'h21);
        if (wl_cyc.size() == 4) check("rr_back_to_back", wl_cyc[3] - wl_cyc[0], 3);

        // Fixed priority
        do_reset();
        bus.wr_hold = 1'b1;
        bus.mode    = ARB_FIXED;
        preload(6'h10, 6'h11, 6'h20, 6'h21);
        clear_log();
        bus.wr_hold = 1'b0;
        repeat (6) tick();
        check_seq("fixed", 4, 6'h10, 6'h11, 6'h20, 6'h21);
        bus.mode = ARB_RR;

        // Full / backpressure on requester 0
        do_reset();
        bus.wr_hold  = 1'b1;
        bus.req0_val = 1'b1; bus.req0_adr = 6'h30; bus.req0_dat = rnd_dat();
        check("full_rdy_a", bus.req0_rdy, 1);
        tick();
        bus.req0_adr = 6'h31; bus.req0_dat = rnd_dat();
        tick();
        bus.req0_adr = 6'h32; bus.req0_dat = rnd_dat();
        check("full_rdy_low", bus.req0_rdy, 0);
        tick();
        check("full_rdy_still_low", bus.req0_rdy, 0);
        bus.wr_hold = 1'b0;
        tick();
        check("full_rdy_back", bus.req0_rdy, 1);
        tick();
        bus.req0_val = 1'b0;
        repeat (5) tick();
        check_seq("full", 3, 6'h30, 6'h31, 6'h32, 6'h00);

        // Hold asserted while a write sits in the output register
        do_reset();
        bus.wr_hold  = 1'b1;
        bus.req0_val = 1'b1; bus.req0_adr = 6'h40; bus.req0_dat = rnd_dat();
        bus.req1_val = 1'b1; bus.req1_adr = 6'h50; bus.req1_dat = rnd_dat();
        tick();
        bus.req1_val = 1'b0;
        bus.req0_adr = 6'h41; bus.req0_dat = rnd_dat();
        tick();
        bus.req0_val = 1'b0;
        clear_log();
        bus.wr_hold = 1'b0;
        tick();
        bus.wr_hold = 1'b1;
        check("hold_cur_enb", bus.wr_enb_0, 1);
        tick();
        check("hold_next_enb", bus.wr_enb_0, 0);
        repeat (2) tick();
        bus.wr_hold = 1'b0;
        repeat (5) tick();
        check_seq("hold", 3, 6'h40, 6'h50, 6'h41, 6'h00);

        // Reset mid-operation discards queued writes
        do_reset();
        bus.wr_hold = 1'b1;
        preload(6'h20, 6'h21, 6'h30, 6'h31);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.wr_hold = 1'b0;
        clear_log();
        repeat (3) tick();
        check("midrst_no_write", wl_adr.size(), 0);
        check("midrst_busy", bus.busy, 0);
        bus.req1_val = 1'b1; bus.req1_adr = 6'h3A; bus.req1_dat = rnd_dat();
        hs = cyc;
        tick();
        bus.req1_val = 1'b0;
        repeat (4) tick();
        check("midrst_count", wl_adr.size(), 1);
        if (wl_adr.size() >= 1) begin
            check("midrst_latency", wl_cyc[0] - hs, 2);
            check("midrst_adr", wl_adr[0], 6'h3A);
        end

        // Randomized traffic; a requester holds its values while stalled
        r0_s = 1'b0;
        r1_s = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 299) != 0);
            bus.wr_hold  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
            if (!(bus.req0_val && !r0_s)) begin
                bus.req0_val = ($urandom_range(0, 9) < 6);
                bus.req0_adr = AW'($urandom());
                bus.req0_dat = rnd_dat();
            end
            if (!(bus.req1_val && !r1_s)) begin
                bus.req1_val = ($urandom_range(0, 9) < 6);
                bus.req1_adr = AW'($urandom());
                bus.req1_dat = rnd_dat();
            end
            #1;
            r0_s = bus.req0_rdy;
            r1_s = bus.req1_rdy;
            @(posedge clk);
            #2;
        end
        bus.req0_val = 1'b0;
        bus.req1_val = 1'b0;
        bus.wr_hold  = 1'b0;
        reset        = 1'b1;
        repeat (10) tick();
        check("drain_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ra_wr_arb
`default_nettype wire
